four_bank_mem: RTL and testbench

//  Banked main-memory model directly downstream of the two-way cache controller.
//  It consumes the controller's rd/wr strobes, byte address and write data, and returns read data

---
 rtl/four_bank_mem.sv | 151 +++++++++++++++
 tb/tb_four_bank_mem.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bank_mem.sv
`default_nettype none
// ============================================================================
//  Module     : four_bank_mem
//  Description: Four-bank interleaved main-memory model for a cache
//               controller. Consecutive 16-bit words go to consecutive banks
//               (bank = addr[2:1]), so a 4-beat line transfer at word
//               offsets 0,2,4,6 streams with no conflicts. Each bank is
//               occupied for BANK_CYCLES cycles per access. A request to an
//               occupied bank is stalled (dropped, not queued). Reads return
//               data with a fixed two-cycle latency.
//  Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1       rising-edge clock
//    rst       in   1       asynchronous reset, active low
//    rd        in   1       read request
//    wr        in   1       write request
//    addr      in   ADDR_W  byte address (addr[0] must be 0)
//    data_in   in   DATA_W  write data
//    data_out  out  DATA_W  read data, valid while rd_valid=1, else holds
//    rd_valid  out  1       one-cycle read-completion pulse
//    stall     out  1       current legal request targets a busy bank
//    busy      out  4       per-bank occupancy
//    err       out  1       previous cycle carried an illegal request
// ============================================================================
module four_bank_mem #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BANK_WORDS  = 2048,
    parameter int BANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);

    localparam int         C_IDX_W    = $clog2(BANK_WORDS);
    localparam logic [3:0] C_CNT_LOAD = 4'(BANK_CYCLES - 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]         w_bank;
    logic [C_IDX_W-1:0] w_idx;
    logic               w_req;
    logic               w_illegal;
    logic               w_accept;
    logic               w_rd_accept;

    assign w_bank      = addr[2:1];
    // Bits above the index range are dropped, so high addresses alias.
    assign w_idx       = addr[3 +: C_IDX_W];
    assign w_req       = rd | wr;
    assign w_illegal   = (rd & wr) | (w_req & addr[0]);
    assign w_accept    = w_req & ~w_illegal & ~busy[w_bank];
    assign w_rd_accept = w_accept & rd;
    assign stall       = w_req & ~w_illegal & busy[w_bank];

    generate
        if (C_IDX_W + 3 < ADDR_W) begin : g_unused_addr
            logic w_unused;
            assign w_unused = &{1'b0, addr[ADDR_W-1:C_IDX_W+3]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-bank storage, read register and occupancy counter
    // ------------------------------------------------------------------
    logic [3:0][DATA_W-1:0] w_bank_rdata;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_bank
            logic [DATA_W-1:0] r_mem [BANK_WORDS];
            logic [DATA_W-1:0] r_rdata;
            logic [3:0]        r_cnt;
            logic              w_sel;

            assign w_sel = w_accept && (w_bank == 2'(b));

            // Storage is deliberately outside the reset domain: contents
            // survive a reset.
            always_ff @(posedge clk) begin
                if (w_sel && wr) begin
                    r_mem[w_idx] <= data_in;
                end
                if (w_sel && rd) begin
                    r_rdata <= r_mem[w_idx];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= 4'd0;
                end else if (w_sel) begin
                    r_cnt <= C_CNT_LOAD;
                end else if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end

            assign busy[b]         = (r_cnt != 4'd0);
            assign w_bank_rdata[b] = r_rdata;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read pipeline. Stage 1 is the per-bank read register written at the
    // accept edge plus the valid/bank tag below. The bank register cannot
    // be overwritten before it is forwarded: a second read to the same bank
    // is blocked by busy for at least one more cycle.
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [1:0]        r_s1_bank;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bank  <= 2'd0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_s1_bank <= w_bank;
            end
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data_out <= w_bank_rdata[r_s1_bank];
            end
            r_err <= w_illegal;
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_four_bank_mem.sv
`default_nettype none
// ============================================================================
//  Module     : tb_four_bank_mem
//  Description: Self-checking bench for four_bank_mem. A reference model
//               tracks memory as a word-keyed associative array, bank
//               occupancy as "edge of last accept" per bank, and expected
//               read completions as a time-stamped queue. A second instance
//               built with BANK_CYCLES=2 is exercised with fixed patterns.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_four_bank_mem;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 2048;
    localparam int BC = 4;
    localparam int NP = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid, stall, err;
    logic [3:0]    busy;

    logic          rd2 = 1'b0, wr2 = 1'b0;
    logic [AW-1:0] addr2 = '0;
    logic [DW-1:0] data_in2 = '0;
    logic [DW-1:0] data_out2;
    logic          rd_valid2, stall2, err2;
    logic [3:0]    busy2;

    always #5 clk = ~clk;

    four_bank_mem #(.ADDR_W(AW), .DATA_W(DW), .BANK_WORDS(BW), .BANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .rd_valid(rd_valid), .stall(stall), .busy(busy), .err(err)
    );

    four_bank_mem #(.ADDR_W(AW), .DATA_W(DW), .BANK_WORDS(BW), .BANK_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .rd(rd2), .wr(wr2), .addr(addr2), .data_in(data_in2),
        .data_out(data_out2), .rd_valid(rd_valid2), .stall(stall2), .busy(busy2), .err(err2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    int          vectors    = 0;
    int          miscompares = 0;
    int          edge_n     = 0;
    int          last_acc[4];
    bit          prev_ill;
    logic [15:0] last_dout;
    logic [15:0] mem_m [int];
    rd_t         rq[$];
    bit          obs_stall;
    int          rv_seen;
    logic [15:0] pool[NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) last_acc[b] = -100;
        rq.delete();
        prev_ill  = 1'b0;
        last_dout = 16'h0000;
    endtask

    function automatic int word_key(input logic [15:0] a);
        // Total storage is 4*BW words; anything above that aliases.
        return int'(a >> 1) % (4 * BW);
    endfunction

    // Compare every output during the cycle before the next rising edge.
    task automatic check_cycle(input string tag);
        logic [3:0]  eb;
        bit          ill, ev;
        for (int b = 0; b < 4; b++) eb[b] = ((edge_n + 1 - last_acc[b]) < BC);
        ill = (rd && wr) || ((rd || wr) && addr[0]);
        ev  = 1'b0;
        if (rq.size() > 0 && rq[0].due == edge_n) begin
            ev        = 1'b1;
            last_dout = rq[0].d;
            void'(rq.pop_front());
        end
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".stall"},    32'(stall),    32'((rd || wr) && !ill && eb[addr[2:1]]));
        chk({tag, ".err"},      32'(err),      32'(prev_ill));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev));
        chk({tag, ".data_out"}, 32'(data_out), 32'(last_dout));
        obs_stall = stall;
        if (rd_valid === 1'b1) rv_seen++;
    endtask

    task automatic step(input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input string tag);
        bit       ill, acc;
        int       b;
        rd = r; wr = w; addr = a; data_in = d;
        @(negedge clk);
        check_cycle(tag);
        @(posedge clk);
        edge_n++;
        ill = (r && w) || ((r || w) && a[0]);
        b   = int'(a[2:1]);
        acc = (r != w) && !a[0] && ((edge_n - last_acc[b]) >= BC);
        if (acc) begin
            last_acc[b] = edge_n;
            if (w) mem_m[word_key(a)] = d;
            else   rq.push_back('{edge_n + 1, mem_m[word_key(a)]});
        end
        prev_ill = ill;
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) step(1'b0, 1'b0, 16'h0000, 16'h0000, tag);
    endtask

    task automatic do_reset(input int n);
        rd = 1'b0; wr = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk);
            check_cycle("reset");
            @(posedge clk);
            edge_n++;
        end
        #1 rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          nst;
        int          op, p;
        logic [15:0] a, d;
        bit          s_exp[8]  = '{1, 0, 1, 0, 1, 0, 0, 0};
        bit          b_exp[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
        bit          v_exp[8]  = '{0, 0, 0, 1, 0, 1, 0, 1};

        model_reset();
        #2;
        do_reset(2);

        // Preload words used by later directed reads.
        step(1'b0, 1'b1, 16'h0000, 16'h5A5A, "pre0");
        step(1'b0, 1'b1, 16'h0002, 16'h3C3C, "pre2");
        idle(3, "pre_idle");

        // 1: write, idle, read back.
        step(1'b0, 1'b1, 16'h0010, 16'hA5A5, "t1.wr");
        idle(4, "t1.idle");
        rv_seen = 0;
        step(1'b1, 1'b0, 16'h0010, 16'h0000, "t1.rd");
        idle(3, "t1.wait");
        chk("t1.rd_valid_count", 32'(rv_seen), 32'd1);

        // 2: preload 1..4 across all banks, then a back-to-back line read.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 16'(16'h0100 + 2 * i), 16'(i + 1), "t2.wr");
        idle(4, "t2.idle");
        rv_seen = 0;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000, "t2.rd");
        idle(4, "t2.wait");
        chk("t2.rd_valid_count", 32'(rv_seen), 32'd4);

        // 3: write then immediately read the same bank; read is held.
        step(1'b0, 1'b1, 16'h0008, 16'hBEEF, "t3.wr");
        nst = 0;
        repeat (4) begin
            step(1'b1, 1'b0, 16'h0008, 16'h0000, "t3.rd");
            nst += int'(obs_stall);
        end
        idle(4, "t3.wait");
        chk("t3.stall_cycles", 32'(nst), 32'd3);

        // 4: illegal requests, then confirm storage untouched.
        step(1'b1, 1'b1, 16'h0000, 16'hFFFF, "t4.rdwr");
        step(1'b1, 1'b0, 16'h0003, 16'h0000, "t4.odd");
        idle(2, "t4.idle");
        step(1'b1, 1'b0, 16'h0000, 16'h0000, "t4.rdback");
        idle(3, "t4.wait");

        // 5: reset while a read is in flight.
        idle(4, "t5.idle");
        step(1'b1, 1'b0, 16'h0002, 16'h0000, "t5.rd");
        do_reset(2);
        rv_seen = 0;
        step(1'b1, 1'b0, 16'h0002, 16'h0000, "t5.rd_post");
        idle(3, "t5.wait");
        chk("t5.rd_valid_count", 32'(rv_seen), 32'd1);

        // Randomized mixed traffic over a preloaded address pool.
        for (int i = 0; i < NP; i++) begin
            pool[i] = {2'b00, 13'($urandom), 1'b0};
            step(1'b0, 1'b1, pool[i], 16'($urandom), "rnd.pre");
            idle(3, "rnd.pre_idle");
        end
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            p  = int'($urandom_range(0, NP - 1));
            a  = pool[p] | (16'($urandom_range(0, 3)) << 14);
            d  = 16'($urandom);
            if (i == 200) do_reset(1);
            if (op <= 3)      step(1'b1, 1'b0, a, d, "rnd.rd");
            else if (op <= 6) step(1'b0, 1'b1, a, d, "rnd.wr");
            else if (op == 7) begin
                if ($urandom_range(0, 1) == 0) step(1'b1, 1'b1, a, d, "rnd.ill_rw");
                else                           step(1'b1, 1'b0, a | 16'h0001, d, "rnd.ill_odd");
            end
            else              step(1'b0, 1'b0, a, d, "rnd.idle");
        end
        idle(4, "rnd.drain");

        // 6: BANK_CYCLES=2 instance, held read to bank 1.
        wr2 = 1'b1; addr2 = 16'h0002; data_in2 = 16'h1234;
        @(negedge clk);
        chk("t6.wr_stall", 32'(stall2), 32'd0);
        @(posedge clk); #1;
        wr2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd2 = (i < 6);
            @(negedge clk);
            chk($sformatf("t6.stall[%0d]", i), 32'(stall2), 32'(s_exp[i]));
            chk($sformatf("t6.busy1[%0d]", i), 32'(busy2[1]), 32'(b_exp[i]));
            chk($sformatf("t6.rd_valid[%0d]", i), 32'(rd_valid2), 32'(v_exp[i]));
            if (v_exp[i]) chk($sformatf("t6.data[%0d]", i), 32'(data_out2), 32'h1234);
            @(posedge clk); #1;
        end
        rd2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
